// File: rtl/ucode_seq.sv
// Registered micro-op sequencer: decodes opcodes accepted over valid/ready into
// a one-entry micro-op register, expanding multi-byte ALU ops into two steps.
//
// state   | meaning
// IDLE    | no pending step; may accept a new opcode when the output slot frees
// HI_PEND | step0 of a multi-byte ALU op is held; step1 still to load
module ucode_seq #(
  parameter int OPW  = 8,
  parameter int IDXW = 3,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic [DW-1:0]   w,
  input  logic            carry,
  input  logic            zero,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic            alu_operation,
  output logic            alu_multibyte_result,
  output logic            jump_operation,
  output logic            jump_condition,
  output logic            mov_operation,
  output logic            destination_w,
  output logic            destination_flags,
  output logic            destination_memory,
  output logic            destination_registers,
  output logic            destination_ports,
  output logic [IDXW-1:0] destination_index,
  output logic            ram_operand,
  output logic            duplicate_w,
  output logic [DW-1:0]   uop_w,
  output logic            uop_last,
  output logic            busy
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HI_PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic            alu;
    logic            alu_mb;
    logic            jmp;
    logic            jmp_cond;
    logic            mov;
    logic            dst_w;
    logic            dst_flags;
    logic            dst_mem;
    logic            dst_regs;
    logic            dst_ports;
    logic [IDXW-1:0] dst_idx;
    logic            ram;
    logic            dup_w;
    logic            last;
  } uop_t;

  state_t          state_q, state_d;
  uop_t            uop_q, uop_d;
  uop_t            dec, step1;
  logic            uop_valid_q, uop_valid_d;
  logic [DW-1:0]   w_q, w_d;
  logic [IDXW-1:0] pend_idx_q, pend_idx_d;

  logic [2:0]      cls;
  logic [1:0]      jcc;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            consume;

  assign cls = opcode[OPW-1 -: 3];
  assign jcc = opcode[OPW-4 -: 2];
  assign idx = opcode[IDXW-1:0];

  // Opcode to first (or only) micro-op; jump condition is resolved here so the
  // flags sampled at acceptance are the only ones that ever matter.
  always_comb begin
    dec      = '0;
    dec.last = 1'b1;
    case (cls)
      3'b000: begin
      end
      3'b001: begin
        dec.alu       = 1'b1;
        dec.dst_w     = 1'b1;
        dec.dst_flags = 1'b1;
      end
      3'b010: begin
        dec.alu       = 1'b1;
        dec.alu_mb    = 1'b1;
        dec.dst_w     = 1'b1;
        dec.dst_flags = 1'b1;
        dec.last      = 1'b0;
      end
      3'b011: begin
        dec.jmp = 1'b1;
        case (jcc)
          2'b00:   dec.jmp_cond = 1'b1;
          2'b01:   dec.jmp_cond = carry;
          2'b10:   dec.jmp_cond = zero;
          default: dec.jmp_cond = !zero;
        endcase
      end
      3'b100: begin
        dec.mov      = 1'b1;
        dec.dst_regs = 1'b1;
        dec.dst_idx  = idx;
      end
      3'b101: begin
        dec.mov       = 1'b1;
        dec.dst_ports = 1'b1;
        dec.dst_idx   = idx;
      end
      3'b110: begin
        dec.mov   = 1'b1;
        dec.ram   = 1'b1;
        dec.dst_w = 1'b1;
      end
      default: begin
        dec.mov     = 1'b1;
        dec.dup_w   = 1'b1;
        dec.dst_mem = 1'b1;
      end
    endcase
  end

  always_comb begin
    step1          = '0;
    step1.alu      = 1'b1;
    step1.alu_mb   = 1'b1;
    step1.dst_regs = 1'b1;
    step1.dst_idx  = pend_idx_q;
    step1.last     = 1'b1;
  end

  assign in_ready = rst_n && (state_q == IDLE) && (!uop_valid_q || uop_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = uop_valid_q && uop_ready;

  always_comb begin
    state_d     = state_q;
    uop_d       = uop_q;
    uop_valid_d = uop_valid_q;
    w_d         = w_q;
    pend_idx_d  = pend_idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          uop_d       = dec;
          uop_valid_d = 1'b1;
          w_d         = w;
          pend_idx_d  = idx;
          if (cls == 3'b010) begin
            state_d = HI_PEND;
          end
        end else if (consume) begin
          uop_valid_d = 1'b0;
        end
      end
      HI_PEND: begin
        // Step1 reuses the W captured with step0.
        if (consume) begin
          uop_d       = step1;
          uop_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      uop_q       <= '0;
      uop_valid_q <= 1'b0;
      w_q         <= '0;
      pend_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      uop_q       <= uop_d;
      uop_valid_q <= uop_valid_d;
      w_q         <= w_d;
      pend_idx_q  <= pend_idx_d;
    end
  end

  assign uop_valid             = uop_valid_q;
  assign alu_operation         = uop_q.alu;
  assign alu_multibyte_result  = uop_q.alu_mb;
  assign jump_operation        = uop_q.jmp;
  assign jump_condition        = uop_q.jmp_cond;
  assign mov_operation         = uop_q.mov;
  assign destination_w         = uop_q.dst_w;
  assign destination_flags     = uop_q.dst_flags;
  assign destination_memory    = uop_q.dst_mem;
  assign destination_registers = uop_q.dst_regs;
  assign destination_ports     = uop_q.dst_ports;
  assign destination_index     = uop_q.dst_idx;
  assign ram_operand           = uop_q.ram;
  assign duplicate_w           = uop_q.dup_w;
  assign uop_last              = uop_q.last;
  assign uop_w                 = w_q;
  assign busy                  = (state_q == HI_PEND);

endmodule

// File: tb/tb_ucode_seq.sv
// Directed bench for ucode_seq: a streaming vector table plus hand-written
// multi-byte, backpressure, flag-capture and reset sequences.
module tb_ucode_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] opcode;
  logic [7:0] w;
  logic       carry, zero, in_valid, uop_ready;
  logic       in_ready, uop_valid;
  logic       alu_operation, alu_multibyte_result, jump_operation, jump_condition;
  logic       mov_operation, destination_w, destination_flags, destination_memory;
  logic       destination_registers, destination_ports, ram_operand, duplicate_w;
  logic [2:0] destination_index;
  logic [7:0] uop_w;
  logic       uop_last, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ucode_seq #(.OPW(8), .IDXW(3), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .w(w), .carry(carry), .zero(zero),
    .in_valid(in_valid), .in_ready(in_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .alu_operation(alu_operation), .alu_multibyte_result(alu_multibyte_result),
    .jump_operation(jump_operation), .jump_condition(jump_condition),
    .mov_operation(mov_operation), .destination_w(destination_w),
    .destination_flags(destination_flags), .destination_memory(destination_memory),
    .destination_registers(destination_registers), .destination_ports(destination_ports),
    .destination_index(destination_index), .ram_operand(ram_operand),
    .duplicate_w(duplicate_w), .uop_w(uop_w), .uop_last(uop_last), .busy(busy)
  );

  // {alu, mb, jmp, jcond, mov, dw, dflags, dmem, dregs, dports, idx[2:0], ram, dup, last}
  logic [15:0] act_vec;
  assign act_vec = {alu_operation, alu_multibyte_result, jump_operation, jump_condition,
                    mov_operation, destination_w, destination_flags, destination_memory,
                    destination_registers, destination_ports, destination_index,
                    ram_operand, duplicate_w, uop_last};

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  wv;
    logic        c;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{8'h20, 8'h11, 1'b0, 1'b0, 16'h8601};
    tbl[1]  = '{8'h21, 8'h12, 1'b1, 1'b1, 16'h8601};
    tbl[2]  = '{8'h22, 8'h13, 1'b0, 1'b1, 16'h8601};
    tbl[3]  = '{8'h68, 8'h20, 1'b1, 1'b0, 16'h3001};
    tbl[4]  = '{8'h70, 8'h21, 1'b1, 1'b0, 16'h2001};
    tbl[5]  = '{8'h78, 8'h22, 1'b0, 1'b0, 16'h3001};
    tbl[6]  = '{8'h60, 8'h23, 1'b0, 1'b0, 16'h3001};
    tbl[7]  = '{8'h68, 8'h24, 1'b0, 1'b1, 16'h2001};
    tbl[8]  = '{8'h70, 8'h25, 1'b0, 1'b1, 16'h3001};
    tbl[9]  = '{8'h83, 8'h30, 1'b0, 1'b0, 16'h0899};
    tbl[10] = '{8'hA2, 8'h31, 1'b0, 1'b0, 16'h0851};
    tbl[11] = '{8'hC0, 8'h32, 1'b0, 1'b0, 16'h0C05};
    tbl[12] = '{8'hC7, 8'h33, 1'b1, 1'b1, 16'h0C05};
    tbl[13] = '{8'hE0, 8'h34, 1'b0, 1'b0, 16'h0903};
    tbl[14] = '{8'h00, 8'h35, 1'b0, 1'b0, 16'h0001};

    rst_n = 1'b0; in_valid = 1'b0; uop_ready = 1'b1;
    opcode = 8'h00; w = 8'h00; carry = 1'b0; zero = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_uop_valid", {31'd0, uop_valid}, 32'd0);
    chk("rst_vec", {16'd0, act_vec}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_uop_w", {24'd0, uop_w}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back streaming of single-step ops
    for (int i = 0; i < 15; i++) begin
      opcode = tbl[i].op; w = tbl[i].wv; carry = tbl[i].c; zero = tbl[i].z;
      in_valid = 1'b1;
      #1;
      chk($sformatf("stream_in_ready[%0d]", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("stream_valid[%0d]", i), {31'd0, uop_valid}, 32'd1);
      chk($sformatf("stream_vec[%0d]", i), {16'd0, act_vec}, {16'd0, tbl[i].exp});
      chk($sformatf("stream_w[%0d]", i), {24'd0, uop_w}, {24'd0, tbl[i].wv});
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, uop_valid}, 32'd0);

    // Multi-byte 0x45 with a stall on step0
    opcode = 8'h45; w = 8'h3C; in_valid = 1'b1; uop_ready = 1'b1;
    tick();
    in_valid = 1'b0; uop_ready = 1'b0; w = 8'h00;
    #1;
    chk("mb_step0_vec", {16'd0, act_vec}, 32'hC600);
    chk("mb_step0_busy", {31'd0, busy}, 32'd1);
    chk("mb_step0_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mb_step0_w", {24'd0, uop_w}, 32'h3C);
    tick();
    chk("mb_stall_vec", {16'd0, act_vec}, 32'hC600);
    chk("mb_stall_busy", {31'd0, busy}, 32'd1);
    uop_ready = 1'b1;
    #1;
    chk("mb_pend_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("mb_step1_vec", {16'd0, act_vec}, 32'hC0A9);
    chk("mb_step1_valid", {31'd0, uop_valid}, 32'd1);
    chk("mb_step1_busy", {31'd0, busy}, 32'd0);
    chk("mb_step1_w", {24'd0, uop_w}, 32'h3C);
    chk("mb_step1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("mb_drain_valid", {31'd0, uop_valid}, 32'd0);

    // Flags and W changing after acceptance must not alter the held uop
    opcode = 8'h68; carry = 1'b1; zero = 1'b0; w = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; carry = 1'b0; zero = 1'b1; w = 8'h55; uop_ready = 1'b0;
    tick();
    chk("flag_hold_vec", {16'd0, act_vec}, 32'h3001);
    chk("flag_hold_w", {24'd0, uop_w}, 32'hA5);
    uop_ready = 1'b1;
    tick();
    chk("flag_drain_valid", {31'd0, uop_valid}, 32'd0);

    // Backpressure: 0x83 held while 0xA2 waits
    opcode = 8'h83; w = 8'h01; in_valid = 1'b1;
    tick();
    opcode = 8'hA2; w = 8'h02; uop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_in_ready[%0d]", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_vec[%0d]", k), {16'd0, act_vec}, 32'h0899);
      chk($sformatf("bp_valid[%0d]", k), {31'd0, uop_valid}, 32'd1);
      chk($sformatf("bp_w[%0d]", k), {24'd0, uop_w}, 32'h01);
      tick();
    end
    uop_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_vec", {16'd0, act_vec}, 32'h0851);
    chk("bp_next_w", {24'd0, uop_w}, 32'h02);
    tick();
    chk("bp_drain_valid", {31'd0, uop_valid}, 32'd0);

    // Reset in the middle of a multi-byte op discards step1
    opcode = 8'h41; w = 8'h99; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rmb_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmb_in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rmb_valid", {31'd0, uop_valid}, 32'd0);
    chk("rmb_busy_clr", {31'd0, busy}, 32'd0);
    chk("rmb_vec", {16'd0, act_vec}, 32'd0);
    chk("rmb_w", {24'd0, uop_w}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rmb_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rmb_no_step1", {31'd0, uop_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
